// File: rtl/add_seq_arbiter.sv
// Two-requester round-robin sequencer that serialises a multi-byte add through
// one external 8-bit adder slice, LSB first, and returns a tagged full sum.
module add_seq_arbiter #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] op_a0,
  input  logic [W-1:0] op_b0,
  input  logic         cin0,
  input  logic [W-1:0] op_a1,
  input  logic [W-1:0] op_b1,
  input  logic         cin1,
  output logic         ack0,
  output logic         ack1,
  output logic         res_valid,
  output logic         res_id,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         busy,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_sum,
  input  logic         add_cout
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic           ptr_q;
  logic           id_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   opa_q, opb_q, acc_q;
  logic           carry_q;
  logic [W-1:0]   res_sum_q;
  logic           res_cout_q, res_id_q, res_valid_q;
  logic           ack0_q, ack1_q, busy_q;

  logic           grant1_d;
  logic [W-1:0]   acc_d, opa_d, opb_d;
  logic           last_byte_d;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = opa_q[7:0];
      add_b   = opb_q[7:0];
      add_cin = carry_q;
    end
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant1_d    = req1 & (~req0 | ~ptr_q);
    acc_d       = (acc_q >> 8) | (W'(add_sum) << (W - 8));
    opa_d       = opa_q >> 8;
    opb_d       = opb_q >> 8;
    last_byte_d = (cnt_q == CW'(NBYTES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            id_q    <= grant1_d;
            opa_q   <= grant1_d ? op_a1 : op_a0;
            opb_q   <= grant1_d ? op_b1 : op_b0;
            carry_q <= grant1_d ? cin1 : cin0;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= add_cout;
          opa_q   <= opa_d;
          opb_q   <= opb_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_byte_d) begin
            res_sum_q   <= acc_d;
            res_cout_q  <= add_cout;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            ack0_q      <= ~id_q;
            ack1_q      <= id_q;
            state_q     <= DONE;
          end
        end
        DONE: begin
          res_valid_q <= 1'b0;
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          busy_q      <= 1'b0;
          ptr_q       <= id_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Directed and random bench for add_seq_arbiter; expected sums are queued per
// requester when a request is raised and compared when the result appears.
module tb_add_seq_arbiter;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, cin0, cin1;
  logic [W-1:0] op_a0, op_b0, op_a1, op_b1;
  logic         ack0, ack1, res_valid, res_id, res_cout, busy;
  logic [W-1:0] res_sum;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  add_seq_arbiter #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .op_a0(op_a0), .op_b0(op_b0), .cin0(cin0),
    .op_a1(op_a1), .op_b1(op_b1), .cin1(cin1),
    .ack0(ack0), .ack1(ack1),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout),
    .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // External adder slice.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_res_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [W:0] q0[$];
  logic [W:0] q1[$];
  int         order[$];
  int         cap_cyc[$];

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [W:0] e;
    @(negedge clk);
    cyc++;
    if (busy === 1'b1 && busy_prev !== 1'b1) cap_cyc.push_back(cyc);
    busy_prev = busy;
    if (res_valid === 1'b1) begin
      order.push_back(int'(res_id));
      done_cnt++;
      last_res_cyc = cyc;
      if (res_id === 1'b0 && q0.size() > 0) begin
        e = q0.pop_front();
        chk("result0", {res_cout, res_sum}, e);
      end else if (res_id === 1'b1 && q1.size() > 0) begin
        e = q1.pop_front();
        chk("result1", {res_cout, res_sum}, e);
      end else begin
        chk("result_without_request", 1, 0);
      end
      chk("ack_pair", {ack0, ack1}, {~res_id, res_id});
    end else begin
      chk("ack_without_valid", {ack0, ack1}, 0);
    end
    if (busy !== 1'b1) chk("adder_idle", {add_a, add_b, add_cin}, 0);
  endtask

  task automatic raise(input int r);
    logic [W-1:0] a, b;
    logic         c;
    a = ($urandom_range(7) == 0) ? {W{1'b1}} : W'($urandom);
    b = ($urandom_range(7) == 0) ? W'(0) : W'($urandom);
    c = 1'($urandom_range(1));
    if (r == 0) begin
      op_a0 = a; op_b0 = b; cin0 = c; req0 = 1'b1;
      q0.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    end else begin
      op_a1 = a; op_b1 = b; cin1 = c; req1 = 1'b1;
      q1.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    end
  endtask

  // One cycle of requester behaviour: drop on ack, otherwise maybe issue.
  task automatic tick(input int pct);
    step();
    if (ack0 === 1'b1) req0 = 1'b0;
    else if (!req0 && pct > 0 && int'($urandom_range(99)) < pct) raise(0);
    if (ack1 === 1'b1) req1 = 1'b0;
    else if (!req1 && pct > 0 && int'($urandom_range(99)) < pct) raise(1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      tick(0);
      n++;
    end
    chk(tag, busy, 1);
  endtask

  task automatic wait_result(input string tag, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      tick(0);
      n++;
    end
    chk(tag, done_cnt - start, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q0.size() + q1.size()) > 0 && n < 200) begin
      tick(0);
      n++;
    end
    chk(tag, q0.size() + q1.size(), 0);
  endtask

  initial begin
    int start;
    int n;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
    op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_flags", {res_valid, res_id, res_cout, ack0, ack1, busy}, 0);
    chk("reset_sum", res_sum, 0);

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_busy", busy, 0);
      chk("idle_valid", res_valid, 0);
    end

    // Carry chain; operands changed after capture must not matter.
    op_a0 = 32'h0000_00FF; op_b0 = 32'h0000_0001; cin0 = 1'b0; req0 = 1'b1;
    q0.push_back(33'h0_0000_0100);
    wait_busy("carry_capture");
    op_a0 = 32'hDEAD_BEEF;
    wait_result("carry_done", 12);
    chk("carry_id", res_id, 0);
    chk("carry_sum", res_sum, 32'h0000_0100);
    chk("carry_cout", res_cout, 0);
    chk("carry_latency", last_res_cyc - cap_cyc[$], NB);
    start = done_cnt;
    repeat (4) step();
    chk("carry_single_ack", done_cnt - start, 0);
    chk("carry_hold_sum", res_sum, 32'h0000_0100);

    // Full ripple from carry-in to carry-out.
    op_a1 = 32'hFFFF_FFFF; op_b1 = 32'h0; cin1 = 1'b1; req1 = 1'b1;
    q1.push_back(33'h1_0000_0000);
    wait_result("ripple_done", 14);
    chk("ripple_id", res_id, 1);
    chk("ripple_sum", res_sum, 0);
    chk("ripple_cout", res_cout, 1);
    repeat (2) step();

    // Tie right after reset: grants alternate starting with requester 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    order.delete();
    cap_cyc.delete();
    n = 0;
    while (order.size() < 4 && n < 60) begin
      tick(100);
      n++;
    end
    drain("tie_drain");
    chk("tie_count", order.size() >= 4, 1);
    if (order.size() >= 4) begin
      chk("tie_grant0", order[0], 0);
      chk("tie_grant1", order[1], 1);
      chk("tie_grant2", order[2], 0);
      chk("tie_grant3", order[3], 1);
    end
    chk("tie_caps", cap_cyc.size() >= 4, 1);
    if (cap_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) chk("tie_gap", cap_cyc[i] - cap_cyc[i-1], NB + 2);
    end
    repeat (3) step();

    // Reset two cycles into RUN abandons the op; the held request then completes.
    op_a0 = 32'h1234_5678; op_b0 = 32'h9ABC_DEF0; cin0 = 1'b1; req0 = 1'b1;
    q0.push_back({1'b0, 32'h1234_5678} + {1'b0, 32'h9ABC_DEF0} + 33'd1);
    wait_busy("rst_capture");
    start = done_cnt;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_flags", {res_valid, res_id, res_cout, ack0, ack1, busy}, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_adder", {add_a, add_b, add_cin}, 0);
    step();
    rst = 1'b0;
    chk("rst_no_ack", done_cnt - start, 0);
    wait_result("rst_retry_done", 14);
    chk("rst_retry_id", res_id, 0);
    drain("rst_drain");

    // Random traffic.
    start = done_cnt;
    n = 0;
    while (done_cnt < start + 10000 && n < 85000) begin
      tick(int'($urandom_range(30, 95)));
      n++;
    end
    chk("random_ops", done_cnt - start >= 10000, 1);
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
